// File: rtl/cgra_imem_loader.sv
// rtl/cgra_imem_loader.sv - OBI-fetching loader that streams kernel words into CGRA imem
module cgra_imem_loader #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned IMEM_ADD_WIDTH = 8
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      start_i,
   input  logic                      abort_i,
   input  logic [ADDR_WIDTH-1:0]     src_addr_i,
   input  logic [IMEM_ADD_WIDTH-1:0] dst_addr_i,
   input  logic [IMEM_ADD_WIDTH:0]   len_words_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_o,
   output logic                      data_req_o,
   input  logic                      data_gnt_i,
   input  logic                      data_rvalid_i,
   output logic                      data_we_o,
   output logic [3:0]                data_be_o,
   output logic [ADDR_WIDTH-1:0]     data_addr_o,
   output logic [DATA_WIDTH-1:0]     data_wdata_o,
   input  logic [DATA_WIDTH-1:0]     data_rdata_i,
   output logic [IMEM_ADD_WIDTH-1:0] cgra_ram_addr_o,
   output logic [DATA_WIDTH-1:0]     cgra_ram_wdata_o,
   output logic                      cgra_ram_we_o
);

   // Range check is done two bits wider than the imem address so that
   // dst + len cannot wrap, even for out-of-range len values.
   localparam logic [IMEM_ADD_WIDTH+1:0] DEPTH = (IMEM_ADD_WIDTH+2)'(2**IMEM_ADD_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_WR,
      S_DONE
   } state_t;

   state_t                    state;
   logic [ADDR_WIDTH-1:0]     cur_src;
   logic [IMEM_ADD_WIDTH-1:0] cur_dst;
   logic [IMEM_ADD_WIDTH:0]   remaining;
   logic                      abort_q;

   logic [IMEM_ADD_WIDTH+1:0] dst_end;
   logic                      start_ok;
   logic [ADDR_WIDTH-1:0]     next_src;

   assign dst_end  = {2'b00, dst_addr_i} + {1'b0, len_words_i};
   assign start_ok = (len_words_i != '0) && (dst_end <= DEPTH);
   assign next_src = cur_src + ADDR_WIDTH'(4);

   // The loader only reads the bus; write-side signals are constant.
   assign data_we_o    = 1'b0;
   assign data_be_o    = 4'hF;
   assign data_wdata_o = '0;

   // Transfer FSM: one outstanding read; abort is only acted on when leaving WR
   // so every granted read has its rvalid consumed and its word written.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state            <= S_IDLE;
         cur_src          <= '0;
         cur_dst          <= '0;
         remaining        <= '0;
         abort_q          <= 1'b0;
         busy_o           <= 1'b0;
         done_o           <= 1'b0;
         err_o            <= 1'b0;
         data_req_o       <= 1'b0;
         data_addr_o      <= '0;
         cgra_ram_addr_o  <= '0;
         cgra_ram_wdata_o <= '0;
         cgra_ram_we_o    <= 1'b0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         if (state != S_IDLE && abort_i) begin
            abort_q <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               abort_q <= 1'b0;
               if (start_i) begin
                  cur_src   <= src_addr_i;
                  cur_dst   <= dst_addr_i;
                  remaining <= len_words_i;
                  if (start_ok) begin
                     busy_o      <= 1'b1;
                     data_req_o  <= 1'b1;
                     data_addr_o <= src_addr_i;
                     state       <= S_REQ;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (data_gnt_i) begin
                  data_req_o <= 1'b0;
                  state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (data_rvalid_i) begin
                  cgra_ram_wdata_o <= data_rdata_i;
                  cgra_ram_addr_o  <= cur_dst;
                  cgra_ram_we_o    <= 1'b1;
                  state            <= S_WR;
               end
            end
            S_WR: begin
               cgra_ram_we_o <= 1'b0;
               cur_src       <= next_src;
               cur_dst       <= cur_dst + 1'b1;
               remaining     <= remaining - 1'b1;
               if (remaining == (IMEM_ADD_WIDTH+1)'(1) || abort_q || abort_i) begin
                  done_o <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= S_DONE;
               end else begin
                  data_req_o  <= 1'b1;
                  data_addr_o <= next_src;
                  state       <= S_REQ;
               end
            end
            S_DONE: begin
               abort_q <= 1'b0;
               state   <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cgra_imem_loader.sv
// tb/tb_cgra_imem_loader.sv - directed self-checking bench for cgra_imem_loader
module tb_cgra_imem_loader;

   logic        clk = 1'b0;
   logic        rstn_i = 1'b0;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic [31:0] src_addr_i = '0;
   logic [7:0]  dst_addr_i = '0;
   logic [8:0]  len_words_i = '0;
   logic        busy_o, done_o, err_o, data_req_o, data_we_o, cgra_ram_we_o;
   logic        data_gnt_i = 1'b0;
   logic        data_rvalid_i = 1'b0;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o, data_wdata_o, cgra_ram_wdata_o;
   logic [31:0] data_rdata_i = '0;
   logic [7:0]  cgra_ram_addr_o;

   cgra_imem_loader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .IMEM_ADD_WIDTH(8)) dut (
      .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
      .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_words_i(len_words_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
      .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
      .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
      .cgra_ram_addr_o(cgra_ram_addr_o), .cgra_ram_wdata_o(cgra_ram_wdata_o),
      .cgra_ram_we_o(cgra_ram_we_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // memory model state and configuration
   int          gmax = 0, rmin = 1, rmax = 1;
   int          gcnt = 0, pend_cnt = 0;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;
   logic        last_req = 1'b0, last_gnt = 1'b0;
   logic [31:0] last_addr = '0;
   int          grant_cnt = 0, stable_err = 0, outst_err = 0;
   logic [31:0] gaddr [64];

   // monitor state
   int          cyc = 0, busy_rise = 0, done_cyc = 0;
   int          done_cnt = 0, err_cnt = 0, we_cnt = 0, both_err = 0;
   logic        busy_prev = 1'b0, busy_seen = 1'b0;
   logic [7:0]  wr_addr [64];
   logic [31:0] wr_data [64];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // OBI slave: grant after gcnt cycles, rvalid pend_cnt cycles after grant
   initial begin
      forever begin
         @(negedge clk);
         data_gnt_i    = 1'b0;
         data_rvalid_i = 1'b0;
         if (pend) begin
            if (pend_cnt <= 1) begin
               data_rvalid_i = 1'b1;
               data_rdata_i  = mem_word(pend_addr);
               pend          = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
         if (last_req && !last_gnt && rstn_i) begin
            if (!data_req_o || data_addr_o !== last_addr) stable_err++;
         end
         if (data_req_o) begin
            if (gcnt == 0) begin
               data_gnt_i = 1'b1;
               if (pend) outst_err++;
               pend      = 1'b1;
               pend_addr = data_addr_o;
               pend_cnt  = $urandom_range(rmax, rmin);
               gaddr[grant_cnt % 64] = data_addr_o;
               grant_cnt++;
               gcnt = $urandom_range(gmax, 0);
            end else begin
               gcnt--;
            end
         end
         last_req  = data_req_o;
         last_gnt  = data_gnt_i;
         last_addr = data_addr_o;
      end
   end

   // output monitor
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (busy_o && !busy_prev) busy_rise = cyc;
         if (busy_o) busy_seen = 1'b1;
         busy_prev = busy_o;
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (err_o) err_cnt++;
         if (done_o && err_o) both_err++;
         if (cgra_ram_we_o) begin
            wr_addr[we_cnt % 64] = cgra_ram_addr_o;
            wr_data[we_cnt % 64] = cgra_ram_wdata_o;
            we_cnt++;
         end
      end
   end

   task automatic clear_stats();
      grant_cnt = 0; stable_err = 0; outst_err = 0;
      done_cnt = 0; err_cnt = 0; we_cnt = 0; both_err = 0;
      busy_seen = 1'b0; busy_rise = 0; done_cyc = 0;
   endtask

   task automatic start_pulse(input logic [31:0] s, input logic [7:0] d, input logic [8:0] l);
      @(posedge clk); #1;
      src_addr_i = s; dst_addr_i = d; len_words_i = l; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] T1_DATA [4] = '{32'hEFFF_1000, 32'hEFFB_1004, 32'hEFF7_1008, 32'hEFF3_100C};

   initial begin
      repeat (3) @(posedge clk);
      #1;
      // reset state
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err", err_o, 0);
      check("rst_req", data_req_o, 0);
      check("rst_we", cgra_ram_we_o, 0);
      check("rst_addr", data_addr_o, 0);
      check("rst_ram_addr", cgra_ram_addr_o, 0);
      check("rst_ram_wdata", cgra_ram_wdata_o, 0);
      check("tie_we_be_wdata", {data_we_o, data_be_o, data_wdata_o}, {1'b0, 4'hF, 32'h0});
      rstn_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1: zero-wait, 4 words
      clear_stats();
      gmax = 0; rmin = 1; rmax = 1;
      start_pulse(32'h1000, 8'h00, 9'd4);
      wait_done(100);
      check("t1_we_cnt", we_cnt, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t1_addr%0d", i), wr_addr[i], i);
         check($sformatf("t1_data%0d", i), wr_data[i], T1_DATA[i]);
      end
      check("t1_done_cycle", done_cyc - busy_rise + 1, 13);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_busy_end", busy_o, 0);

      // 2: random latencies, 16 words
      clear_stats();
      gmax = 5; rmin = 1; rmax = 3;
      start_pulse(32'h2000, 8'h20, 9'd16);
      wait_done(1000);
      check("t2_req_stable", stable_err, 0);
      check("t2_outstanding", outst_err, 0);
      check("t2_we_cnt", we_cnt, 16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t2_addr%0d", i), wr_addr[i], 8'h20 + i);
         check($sformatf("t2_data%0d", i), wr_data[i], mem_word(32'h2000 + 4 * i));
      end
      check("t2_done_cnt", done_cnt, 1);
      gmax = 0; rmin = 1; rmax = 1;

      // 3: start rejection and the exact upper boundary
      clear_stats();
      start_pulse(32'h3000, 8'h00, 9'd0);
      repeat (4) @(posedge clk);
      #1;
      check("t3_len0_err", err_cnt, 1);
      check("t3_len0_req", grant_cnt, 0);
      check("t3_len0_busy", busy_seen, 0);
      clear_stats();
      start_pulse(32'h3000, 8'hF0, 9'h11);
      repeat (4) @(posedge clk);
      #1;
      check("t3_ovf_err", err_cnt, 1);
      check("t3_ovf_busy", busy_seen, 0);
      clear_stats();
      start_pulse(32'h3000, 8'hF0, 9'h10);
      wait_done(200);
      check("t3_fit_err", err_cnt, 0);
      check("t3_fit_we", we_cnt, 16);
      check("t3_fit_last", wr_addr[15], 8'hFF);
      check("t3_fit_done", done_cnt, 1);

      // 4: abort while the fourth word is outstanding
      clear_stats();
      start_pulse(32'h4000, 8'h00, 9'd8);
      for (int i = 0; i < 100 && grant_cnt < 4; i++) begin
         @(posedge clk);
         #1;
      end
      abort_i = 1'b1;
      @(posedge clk); #1;
      abort_i = 1'b0;
      wait_done(100);
      check("t4_we_cnt", we_cnt, 4);
      check("t4_last_data", wr_data[3], mem_word(32'h400C));
      check("t4_grants", grant_cnt, 4);
      check("t4_done", done_cnt, 1);
      check("t4_busy", busy_o, 0);

      // 5: reset during WAIT with a late rvalid
      clear_stats();
      rmin = 3; rmax = 3;
      start_pulse(32'h5000, 8'h00, 9'd4);
      for (int i = 0; i < 100 && grant_cnt < 1; i++) begin
         @(posedge clk);
         #1;
      end
      rstn_i = 1'b0;
      @(posedge clk); #1;
      rstn_i = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("t5_we_cnt", we_cnt, 0);
      check("t5_done", done_cnt, 0);
      check("t5_busy", busy_o, 0);
      check("t5_req", data_req_o, 0);
      check("t5_addr", data_addr_o, 0);
      check("t5_ram_addr", cgra_ram_addr_o, 0);
      rmin = 1; rmax = 1;

      // 6: source address wrap, start during busy ignored
      clear_stats();
      start_pulse(32'hFFFF_FFFC, 8'h10, 9'd2);
      @(posedge clk); #1;
      start_pulse(32'h6000, 8'h00, 9'd1);
      wait_done(100);
      check("t6_grants", grant_cnt, 2);
      check("t6_wrap_addr", gaddr[1], 32'h0);
      check("t6_data0", wr_data[0], 32'h0003_FFFC);
      check("t6_data1", wr_data[1], 32'hFFFF_0000);
      check("t6_dst1", wr_addr[1], 8'h11);
      check("t6_err", err_cnt, 0);
      check("t6_done", done_cnt, 1);
      check("done_err_overlap", both_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
